// File: rtl/fs_pkg.sv
// Shared definitions for the bit-serial full subtractor.
package fs_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } fs_state_e;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned CNT_W     = $clog2(WIDTH_DEF);

    // Signed overflow of a - b given the operand and result sign bits.
    function automatic logic fs_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/fs_1bit.sv
// Combinational one-bit full subtractor: d = a - b - br, br_o is the borrow out.
module fs_1bit (
    input  logic a_i,
    input  logic b_i,
    input  logic br_i,
    output logic d_o,
    output logic br_o
);

    assign d_o  = a_i ^ b_i ^ br_i;
    assign br_o = (~a_i & b_i) | (~(a_i ^ b_i) & br_i);

endmodule

// File: rtl/fs_8bits_serial.sv
// Bit-serial 8-bit full subtractor, LSB first, with start/busy/done handshake.
// Optional signed-overflow output ovf_o is enabled by defining FS_SERIAL_OVF_EN.
module fs_8bits_serial
    import fs_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] i0_i,
    input  logic [WIDTH-1:0] i1_i,
    input  logic             bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
`ifdef FS_SERIAL_OVF_EN
    output logic             ovf_o,
`endif
    output logic             bout_o
);

    localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

    fs_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               br_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q;
    logic               done_q;
`ifdef FS_SERIAL_OVF_EN
    logic               ovf_q;
`endif

    logic               d_bit;
    logic               br_d;
    logic [WIDTH-1:0]   res_d;

    // Single subtractor cell reused every cycle on the current LSBs.
    fs_1bit u_fs_1bit (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .br_i (br_q),
        .d_o  (d_bit),
        .br_o (br_d)
    );

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign res_d = {d_bit, res_q[WIDTH-1:1]};

    // FSM, operand/result shift registers and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FS_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        a_q     <= i0_i;
                        b_q     <= i1_i;
                        br_q    <= bin_i;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= br_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LastBit) begin
                        diff_q  <= res_d;
                        bout_q  <= br_d;
                        done_q  <= 1'b1;
                        state_q <= StDone;
`ifdef FS_SERIAL_OVF_EN
                        // On the last bit a_q[0]/b_q[0] hold the captured operand MSBs.
                        ovf_q   <= fs_ovf(a_q[0], b_q[0], d_bit);
`endif
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o = (state_q != StIdle);
    assign done_o = done_q;
    assign diff_o = diff_q;
    assign bout_o = bout_q;
`ifdef FS_SERIAL_OVF_EN
    assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_fs_8bits_serial.sv
// Directed self-checking bench for fs_8bits_serial (covers ovf when FS_SERIAL_OVF_EN is defined).
module tb_fs_8bits_serial;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] i0;
    logic [7:0] i1;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
`ifdef FS_SERIAL_OVF_EN
    logic       ovf;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [7:0]  last_diff;

    fs_8bits_serial #(
        .WIDTH (8)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .i0_i    (i0),
        .i1_i    (i1),
        .bin_i   (bin),
        .busy_o  (busy),
        .done_o  (done),
        .diff_o  (diff),
`ifdef FS_SERIAL_OVF_EN
        .ovf_o   (ovf),
`endif
        .bout_o  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation; inputs are scrambled after the accepting edge.
    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input logic [7:0] ed, input logic eb, input logic eo, input string tag);
        @(negedge clk);
        i0 = a; i1 = b; bin = bi; start = 1'b1;
        @(posedge clk);                         // E1
        @(negedge clk);
        start = 1'b0; i0 = ~a; i1 = ~b; bin = ~bi;
        chk({tag, ".busy_e1"}, {31'd0, busy}, 32'd1);
        chk({tag, ".done_e1"}, {31'd0, done}, 32'd0);
        repeat (7) @(posedge clk);              // E8
        @(negedge clk);
        chk({tag, ".done_e8"}, {31'd0, done}, 32'd0);
        chk({tag, ".diff_hold"}, {24'd0, diff}, {24'd0, last_diff});
        @(posedge clk);                         // E9
        @(negedge clk);
        chk({tag, ".done_e9"}, {31'd0, done}, 32'd1);
        chk({tag, ".busy_e9"}, {31'd0, busy}, 32'd1);
        chk({tag, ".diff"}, {24'd0, diff}, {24'd0, ed});
        chk({tag, ".bout"}, {31'd0, bout}, {31'd0, eb});
`ifdef FS_SERIAL_OVF_EN
        chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
        if (eo === 1'bx) $display("note: bad ovf arg in %s", tag);
`endif
        @(posedge clk);                         // E10
        @(negedge clk);
        chk({tag, ".done_e10"}, {31'd0, done}, 32'd0);
        chk({tag, ".busy_e10"}, {31'd0, busy}, 32'd0);
        chk({tag, ".diff_e10"}, {24'd0, diff}, {24'd0, ed});
        last_diff = ed;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; i0 = 8'd0; i1 = 8'd0; bin = 1'b0;
        last_diff = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.diff", {24'd0, diff}, 32'd0);
        chk("rst.bout", {31'd0, bout}, 32'd0);
`ifdef FS_SERIAL_OVF_EN
        chk("rst.ovf", {31'd0, ovf}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("idle.busy", {31'd0, busy}, 32'd0);

        op(8'd29, 8'd5, 1'b0, 8'd24, 1'b0, 1'b0, "basic");
        op(8'd5, 8'd29, 1'b0, 8'd232, 1'b1, 1'b0, "underflow");
        op(8'd0, 8'd0, 1'b1, 8'd255, 1'b1, 1'b0, "bin_zero");
        op(8'd200, 8'd95, 1'b0, 8'd105, 1'b0, 1'b1, "ovf_pos");

        // Reset at E5 of 191-2, with start also held to check rst priority.
        @(negedge clk);
        i0 = 8'd191; i1 = 8'd2; bin = 1'b0; start = 1'b1;
        @(posedge clk);                         // E1
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);              // E4
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(posedge clk);                         // E5
        @(negedge clk);
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        chk("midrst.done", {31'd0, done}, 32'd0);
        chk("midrst.diff", {24'd0, diff}, 32'd0);
        chk("midrst.bout", {31'd0, bout}, 32'd0);
`ifdef FS_SERIAL_OVF_EN
        chk("midrst.ovf", {31'd0, ovf}, 32'd0);
`endif
        rst = 1'b0; start = 1'b0;
        last_diff = 8'd0;
        op(8'd191, 8'd2, 1'b0, 8'd189, 1'b0, 1'b0, "after_rst");
        op(8'd51, 8'd92, 1'b0, 8'd215, 1'b1, 1'b0, "ovf_neg");

        // Start held high throughout; operands change during RUN.
        @(negedge clk);
        i0 = 8'd78; i1 = 8'd43; bin = 1'b0; start = 1'b1;
        @(posedge clk);                         // E1
        @(negedge clk);
        i0 = 8'd10; i1 = 8'd3;
        chk("b2b.busy_e1", {31'd0, busy}, 32'd1);
        repeat (8) @(posedge clk);              // E9
        @(negedge clk);
        chk("b2b.done", {31'd0, done}, 32'd1);
        chk("b2b.diff", {24'd0, diff}, 32'd35);
        chk("b2b.bout", {31'd0, bout}, 32'd0);
        @(posedge clk);                         // E10, start ignored in DONE
        @(negedge clk);
        chk("b2b.busy_e10", {31'd0, busy}, 32'd0);
        chk("b2b.done_e10", {31'd0, done}, 32'd0);
        @(posedge clk);                         // E11 accepts 10-3
        @(negedge clk);
        start = 1'b0;
        chk("b2b.busy_e11", {31'd0, busy}, 32'd1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("b2b2.done", {31'd0, done}, 32'd1);
        chk("b2b2.diff", {24'd0, diff}, 32'd7);
        chk("b2b2.bout", {31'd0, bout}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b2.busy_end", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
